// File: rtl/dfr_axi_cfg_slave.sv
// -----------------------------------------------------------------------------
// dfr_axi_cfg_slave
//   AXI4-Lite responder for the DFR core. It decodes the control/count register
//   window (region 0) and four memory windows (regions 1..4: input, reservoir,
//   weight, output). It holds the configuration registers and turns bus
//   accesses into single-beat word accesses on the DFR memory port.
//   One transaction is in flight at a time, and writes win over reads.
//
// Optional feature macro: DFR_AXI_SLVERR_EN
//   defined   : unmapped accesses, DEBUG writes and count-register writes
//               while busy answer SLVERR (2'b10). A memory-window address with
//               bits set above the memory word range counts as unmapped and
//               issues no memory strobe.
//   undefined : every response is OKAY and dropped writes are silent.
//
// Ports
//   S_AXI_ACLK / S_AXI_ARESET   clock, asynchronous active-high reset
//   S_AXI_AW*/W*/B*/AR*/R*      AXI4-Lite slave channels (WSTRB ignored)
//   busy                        core running; gates launch and count writes
//   debug_in                    value returned by the DEBUG register
//   ctrl_reg, ctrl_start        CTRL contents and one-cycle launch pulse
//   num_*                       count registers
//   mem_sel/mem_addr/mem_wr_en/mem_rd_en/mem_wdata/mem_rdata
//                               DFR memory port (word addressed)
// -----------------------------------------------------------------------------
module dfr_axi_cfg_slave #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 30,
  parameter int MEM_ADDR_WIDTH     = 16,
  parameter int MEM_RD_LATENCY     = 1
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  input  logic                            busy,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   debug_in,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   ctrl_reg,
  output logic                            ctrl_start,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   num_init_samples,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   num_train_samples,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   num_test_samples,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   num_steps_per_sample,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   num_init_steps,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   num_train_steps,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   num_test_steps,
  output logic [1:0]                      mem_sel,
  output logic [MEM_ADDR_WIDTH-1:0]       mem_addr,
  output logic                            mem_wr_en,
  output logic                            mem_rd_en,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   mem_wdata,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   mem_rdata
);

  localparam int AW = C_S_AXI_ADDR_WIDTH;
  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam logic [1:0] RESP_OKAY = 2'b00;
`ifdef DFR_AXI_SLVERR_EN
  localparam logic [1:0] RESP_ERR  = 2'b10;
`else
  localparam logic [1:0] RESP_ERR  = 2'b00;
`endif
  localparam logic [2:0] RD_LAT = 3'(MEM_RD_LATENCY);

  typedef enum logic [2:0] {IDLE, WR_MEM, WR_RESP, RD_WAIT, RD_RESP} state_t;

  state_t            state_q;
  logic              awready_q, arready_q, bvalid_q, rvalid_q;
  logic [1:0]        bresp_q, rresp_q;
  logic [DW-1:0]     rdata_q;
  logic [AW-1:2]     waddr_q;
  logic [DW-1:0]     wdata_q;
  logic [DW-1:0]     ctrl_q;
  logic [DW-1:0]     cnt_q [7];
  logic              ctrl_start_q;
  logic [1:0]        mem_sel_q;
  logic [MEM_ADDR_WIDTH-1:0] mem_addr_q;
  logic [DW-1:0]     mem_wdata_q;
  logic              mem_wr_en_q, mem_rd_en_q;
  logic [2:0]        lat_q;

  // True when the address falls in one of the four memory windows.
  function automatic logic is_mem_win(input logic [29:0] a);
    logic hit;
    hit = (a[29:24] >= 6'd1) && (a[29:24] <= 6'd4);
`ifdef DFR_AXI_SLVERR_EN
    hit = hit && ((a[23:0] >> (MEM_ADDR_WIDTH + 2)) == 24'd0);
`endif
    return hit;
  endfunction

  // Region 1..4 maps to memory select 0..3.
  function automatic logic [1:0] sel_of(input logic [29:0] a);
    return a[25:24] - 2'd1;
  endfunction

  logic          rd_mem_d, rd_err_d, wr_mem_d;
  logic [DW-1:0] rd_data_d;
  logic [2:0]    wr_idx_d;
  logic          unused_bits;

  assign rd_mem_d    = is_mem_win(S_AXI_ARADDR[29:0]);
  assign wr_mem_d    = is_mem_win({waddr_q[29:2], 2'b00});
  // Word offsets 0x08..0x20 land on count slots 0..6 (0x20 wraps [4:2] to 0).
  assign wr_idx_d    = waddr_q[4:2] - 3'd2;
  assign unused_bits = ^{S_AXI_WSTRB, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  always_comb begin
    rd_data_d = '0;
    rd_err_d  = 1'b0;
    if (S_AXI_ARADDR[29:24] == 6'd0) begin
      case (S_AXI_ARADDR[23:2])
        22'd0:   rd_data_d = {ctrl_q[DW-1:1], busy};
        22'd1:   rd_data_d = debug_in;
        22'd2:   rd_data_d = cnt_q[0];
        22'd3:   rd_data_d = cnt_q[1];
        22'd4:   rd_data_d = cnt_q[2];
        22'd5:   rd_data_d = cnt_q[3];
        22'd6:   rd_data_d = cnt_q[4];
        22'd7:   rd_data_d = cnt_q[5];
        22'd8:   rd_data_d = cnt_q[6];
        default: rd_err_d  = 1'b1;
      endcase
    end else if (!rd_mem_d) begin
      rd_err_d = 1'b1;
    end
  end

  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      state_q      <= IDLE;
      awready_q    <= 1'b0;
      arready_q    <= 1'b0;
      bvalid_q     <= 1'b0;
      rvalid_q     <= 1'b0;
      bresp_q      <= RESP_OKAY;
      rresp_q      <= RESP_OKAY;
      rdata_q      <= '0;
      waddr_q      <= '0;
      wdata_q      <= '0;
      ctrl_q       <= '0;
      for (int i = 0; i < 7; i++) cnt_q[i] <= '0;
      ctrl_start_q <= 1'b0;
      mem_sel_q    <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_wr_en_q  <= 1'b0;
      mem_rd_en_q  <= 1'b0;
      lat_q        <= '0;
    end else begin
      awready_q    <= 1'b0;
      arready_q    <= 1'b0;
      ctrl_start_q <= 1'b0;
      mem_wr_en_q  <= 1'b0;
      mem_rd_en_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (awready_q) begin
            // AW/W handshake completes on this edge: act on the latched write.
            if (wr_mem_d) begin
              mem_sel_q   <= sel_of({waddr_q[29:2], 2'b00});
              mem_addr_q  <= waddr_q[MEM_ADDR_WIDTH+1:2];
              mem_wdata_q <= wdata_q;
              mem_wr_en_q <= 1'b1;
              state_q     <= WR_MEM;
            end else begin
              bresp_q <= RESP_OKAY;
              if (waddr_q[29:24] == 6'd0) begin
                case (waddr_q[23:2])
                  22'd0: begin
                    ctrl_q       <= wdata_q;
                    ctrl_start_q <= wdata_q[0] & ~busy;
                  end
                  22'd2, 22'd3, 22'd4, 22'd5, 22'd6, 22'd7, 22'd8: begin
                    if (busy) bresp_q <= RESP_ERR;
                    else      cnt_q[wr_idx_d] <= wdata_q;
                  end
                  default: bresp_q <= RESP_ERR;  // DEBUG or unmapped offset
                endcase
              end else begin
                bresp_q <= RESP_ERR;
              end
              bvalid_q <= 1'b1;
              state_q  <= WR_RESP;
            end
          end else if (S_AXI_AWVALID && S_AXI_WVALID) begin
            awready_q <= 1'b1;
            waddr_q   <= S_AXI_AWADDR[AW-1:2];
            wdata_q   <= S_AXI_WDATA;
          end else if (S_AXI_ARVALID) begin
            arready_q <= 1'b1;
            if (rd_mem_d) begin
              // Strobe the memory alongside ARREADY to keep read latency minimal.
              mem_sel_q   <= sel_of(S_AXI_ARADDR[29:0]);
              mem_addr_q  <= S_AXI_ARADDR[MEM_ADDR_WIDTH+1:2];
              mem_rd_en_q <= 1'b1;
              lat_q       <= '0;
              state_q     <= RD_WAIT;
            end else begin
              rdata_q <= rd_data_d;
              rresp_q <= rd_err_d ? RESP_ERR : RESP_OKAY;
              state_q <= RD_RESP;
            end
          end
        end
        WR_MEM: begin
          bresp_q  <= RESP_OKAY;
          bvalid_q <= 1'b1;
          state_q  <= WR_RESP;
        end
        WR_RESP: begin
          if (S_AXI_BREADY) begin
            bvalid_q <= 1'b0;
            state_q  <= IDLE;
          end
        end
        RD_WAIT: begin
          if (lat_q == RD_LAT) begin
            rdata_q  <= mem_rdata;
            rresp_q  <= RESP_OKAY;
            rvalid_q <= 1'b1;
            state_q  <= RD_RESP;
          end else begin
            lat_q <= lat_q + 3'd1;
          end
        end
        RD_RESP: begin
          // Register reads arrive here with RVALID still low; raise it one cycle later.
          if (!rvalid_q) begin
            rvalid_q <= 1'b1;
          end else if (S_AXI_RREADY) begin
            rvalid_q <= 1'b0;
            state_q  <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign S_AXI_AWREADY        = awready_q;
  assign S_AXI_WREADY         = awready_q;
  assign S_AXI_BRESP          = bresp_q;
  assign S_AXI_BVALID         = bvalid_q;
  assign S_AXI_ARREADY        = arready_q;
  assign S_AXI_RDATA          = rdata_q;
  assign S_AXI_RRESP          = rresp_q;
  assign S_AXI_RVALID         = rvalid_q;
  assign ctrl_reg             = ctrl_q;
  assign ctrl_start           = ctrl_start_q;
  assign num_init_samples     = cnt_q[0];
  assign num_train_samples    = cnt_q[1];
  assign num_test_samples     = cnt_q[2];
  assign num_steps_per_sample = cnt_q[3];
  assign num_init_steps       = cnt_q[4];
  assign num_train_steps      = cnt_q[5];
  assign num_test_steps       = cnt_q[6];
  assign mem_sel              = mem_sel_q;
  assign mem_addr             = mem_addr_q;
  assign mem_wr_en            = mem_wr_en_q;
  assign mem_rd_en            = mem_rd_en_q;
  assign mem_wdata            = mem_wdata_q;

endmodule

// File: doc/dfr_axi_cfg_slave.md
# dfr_axi_cfg_slave

AXI4-Lite responder that terminates the host bus inside `dfr_core_top`. It decodes the control/count register window and the four memory windows (input, reservoir, weight, output). It holds the DFR configuration registers and issues single-beat word accesses to the DFR memories. It is the slave counterpart of the host-side AXI master driver used to load samples and weights, launch the core and read results.

## Interface
- `C_S_AXI_DATA_WIDTH`, 32, data width; only 32 supported
- `C_S_AXI_ADDR_WIDTH`, 30, byte address width
- `MEM_ADDR_WIDTH`, 16, word address width of each DFR memory
- `MEM_RD_LATENCY`, 1, cycles from `mem_rd_en` to valid `mem_rdata`; range 1..4
- `S_AXI_ACLK` in 1 — single clock
- `S_AXI_ARESET` in 1 — reset, asynchronous, active-high
- `S_AXI_AWADDR` in 30, `S_AXI_AWVALID` in 1, `S_AXI_AWREADY` out 1 — write address channel
- `S_AXI_WDATA` in 32, `S_AXI_WSTRB` in 4, `S_AXI_WVALID` in 1, `S_AXI_WREADY` out 1 — write data channel; WSTRB ignored, full-word writes only
- `S_AXI_BRESP` out 2, `S_AXI_BVALID` out 1, `S_AXI_BREADY` in 1 — write response channel
- `S_AXI_ARADDR` in 30, `S_AXI_ARVALID` in 1, `S_AXI_ARREADY` out 1 — read address channel
- `S_AXI_RDATA` out 32, `S_AXI_RRESP` out 2, `S_AXI_RVALID` out 1, `S_AXI_RREADY` in 1 — read data channel
- `busy` in 1 — DFR core running
- `debug_in` in 32 — value returned by DEBUG register
- `ctrl_reg` out 32 — CTRL register contents
- `ctrl_start` out 1 — one-cycle launch pulse
- `num_init_samples`, `num_train_samples`, `num_test_samples`, `num_steps_per_sample`, `num_init_steps`, `num_train_steps`, `num_test_steps` out 32 each — count registers
- `mem_sel` out 2 — 0 input, 1 reservoir, 2 weight, 3 output
- `mem_addr` out MEM_ADDR_WIDTH — word address, AWADDR/ARADDR[MEM_ADDR_WIDTH+1:2]
- `mem_wr_en` out 1, `mem_rd_en` out 1, `mem_wdata` out 32, `mem_rdata` in 32

## Operation
- Region decode on address bits [29:24]:
  - 0x00 → registers.
  - 0x01..0x04 → memory, `mem_sel` = region−1.
  - Any other region → unmapped.
- Register map, region 0, byte offsets:
  - 0x00 CTRL (rw)
  - 0x04 DEBUG (ro, reads `debug_in`)
  - 0x08 INIT_SAMPLES, 0x0C TRAIN_SAMPLES, 0x10 TEST_SAMPLES, 0x14 STEPS_PER_SAMPLE
  - 0x18 INIT_STEPS, 0x1C TRAIN_STEPS, 0x20 TEST_STEPS
  - Offsets above 0x20 are unmapped.
- Single FSM, states IDLE, WR_MEM, WR_RESP, RD_WAIT, RD_RESP:
  - IDLE: AWVALID && WVALID both high → write accepted, write has priority. Otherwise ARVALID high → read accepted.
  - Register write: update register, go to WR_RESP. Memory write: go to WR_MEM.
  - WR_MEM: `mem_wr_en`=1 for one cycle with `mem_sel`/`mem_addr`/`mem_wdata`, then WR_RESP.
  - WR_RESP: BVALID=1 held until BREADY sampled high, then IDLE.
  - Register read: RDATA captured, go to RD_RESP. Memory read: `mem_rd_en` pulses one cycle, then RD_WAIT.
  - RD_WAIT: lasts MEM_RD_LATENCY cycles, then `mem_rdata` is captured into RDATA and the FSM goes to RD_RESP.
  - RD_RESP: RVALID=1 held, RDATA/RRESP stable, until RREADY sampled high, then IDLE.
- CTRL write with bit0=1 while `busy`=0 → `ctrl_start` pulses high for the cycle after the handshake.
- CTRL bit0 reads back as `busy`; other CTRL bits read back as written.
- Count register writes while `busy`=1 are dropped; register value is unchanged.
- Writes to DEBUG are dropped.
- Unmapped reads return 0.

## Timing
- Reset values: all outputs 0, all registers 0, FSM in IDLE.
- AWREADY and WREADY pulse together for exactly one cycle, in the cycle after both VALIDs are sampled high. ARREADY pulses likewise.
- BVALID asserts no later than 2 cycles after the AW/W handshake: 1 cycle for a register write, 2 for a memory write.
- Read latency, ARREADY to RVALID: register read 1 cycle; memory read MEM_RD_LATENCY+1 cycles.
- No new address is accepted while BVALID or RVALID is high. One transaction is outstanding at a time.
- Reset asserted mid-transaction: all VALID/READY outputs and `mem_*_en` drop immediately; the pending transaction is lost.

## Configuration
- `DFR_AXI_SLVERR_EN` defined:
  - Unmapped accesses, DEBUG writes and count-register writes while busy return RESP=2'b10 (SLVERR).
  - Unmapped memory-region accesses issue no `mem_*_en`.
- Not defined: every response is 2'b00 (OKAY); dropped writes remain silently dropped.

## Test plan
- Write 100 to 0x0008, then read 0x0008 → RDATA=100, RRESP=0; `num_init_samples`=100.
- Write 0xFFFF_FFD6 to 0x0100_0008 → `mem_wr_en` for one cycle with `mem_sel`=0, `mem_addr`=2, `mem_wdata`=0xFFFF_FFD6; BVALID follows 1 cycle later.
- With MEM_RD_LATENCY=2, read 0x0400_000C while the model drives `mem_rdata`=1234 → `mem_sel`=3, `mem_addr`=3; RVALID asserts 3 cycles after ARREADY with RDATA=1234.
- Write 1 to CTRL with busy=0 → single `ctrl_start` pulse; hold busy=1 and read CTRL → bit0=1. Write 5 to 0x0014 while busy → register unchanged; BRESP=2 with macro defined, 0 without.
- Read 0x0000_0024 and 0x0500_0000 → RDATA=0 and no `mem_rd_en`; RRESP=2 with macro defined, 0 without.
- Hold RREADY low for 5 cycles during RD_RESP → RVALID/RDATA stable throughout. Assert reset during RD_WAIT → RVALID stays 0 and the next read completes normally.
